fetch_stage: RTL and testbench

- Instruction fetch stage; sits directly upstream of decoder_stage.
- Holds the PC and issues requests to instruction memory over a syn/ack handshake.
- Delivers instr/pc/ce to the decoder at up to 1 instr/cycle.
- Handles downstream stall (1-entry skid buffer), flush and PC redirect from branch/jump resolution.

---
 rtl/fetch_stage_if.sv | 40 ++++
 rtl/fetch_stage.sv | 148 ++++++++++++++
 tb/tb_fetch_stage.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: memory request/response and decoder-facing signals of the
// instruction fetch stage. master = fetch stage side, slave = environment side.
// Optional macro FETCH_MISALIGN_EXC_EN adds fs_o_exception.
interface fetch_stage_if #(
    parameter int PC_WIDTH = 32,
    parameter int IWIDTH   = 32
);
    logic [PC_WIDTH-1:0] fs_o_iaddr;
    logic                fs_o_syn;
    logic                fs_i_ack;
    logic [IWIDTH-1:0]   fs_i_instr;
    logic                fs_i_change_pc;
    logic [PC_WIDTH-1:0] fs_i_pc_target;
    logic                fs_i_stall;
    logic                fs_i_flush;
    logic [IWIDTH-1:0]   fs_o_instr;
    logic [PC_WIDTH-1:0] fs_o_pc;
    logic                fs_o_ce;
`ifdef FETCH_MISALIGN_EXC_EN
    logic                fs_o_exception;
`endif

    modport master (
`ifdef FETCH_MISALIGN_EXC_EN
        output fs_o_exception,
`endif
        output fs_o_iaddr, fs_o_syn, fs_o_instr, fs_o_pc, fs_o_ce,
        input  fs_i_ack, fs_i_instr, fs_i_change_pc, fs_i_pc_target,
        input  fs_i_stall, fs_i_flush
    );

    modport slave (
`ifdef FETCH_MISALIGN_EXC_EN
        input  fs_o_exception,
`endif
        input  fs_o_iaddr, fs_o_syn, fs_o_instr, fs_o_pc, fs_o_ce,
        output fs_i_ack, fs_i_instr, fs_i_change_pc, fs_i_pc_target,
        output fs_i_stall, fs_i_flush
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: holds the PC, requests instructions over syn/ack, and hands
// instr/pc/ce to the decoder with a one-entry skid buffer for stalls.
// Redirect (change_pc) beats flush, flush beats stall/ack.
// Optional macro FETCH_MISALIGN_EXC_EN: a misaligned redirect target raises
// fs_o_exception with a NOP and parks the stage until the next flush/redirect;
// without it the target's low two bits are forced to zero.
module fetch_stage #(
    parameter int                  PC_WIDTH = 32,
    parameter int                  IWIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input logic           fs_clk,
    input logic           fs_rst,
    fetch_stage_if.master fs
);
    typedef enum logic [1:0] {IDLE, REQ, SKID, BUBBLE} state_t;

    localparam logic [IWIDTH-1:0] NOP = IWIDTH'(32'h0000_0013);

    state_t              state, state_nx;
    logic [PC_WIDTH-1:0] pc, pc_nx;
    logic [IWIDTH-1:0]   out_instr, out_instr_nx;
    logic [PC_WIDTH-1:0] out_pc, out_pc_nx;
    logic                out_ce, out_ce_nx;
    logic [IWIDTH-1:0]   skid_instr, skid_instr_nx;
    logic [PC_WIDTH-1:0] skid_pc, skid_pc_nx;
    logic [PC_WIDTH-1:0] target;
`ifdef FETCH_MISALIGN_EXC_EN
    logic                exc, exc_nx;
    logic                misaligned;

    assign target     = fs.fs_i_pc_target;
    assign misaligned = (fs.fs_i_pc_target[1:0] != 2'b00);
    assign fs.fs_o_exception = exc;
`else
    assign target = fs.fs_i_pc_target & ~PC_WIDTH'(3);
`endif

    // Request is live only in REQ; the address is always the current PC.
    assign fs.fs_o_syn   = (state == REQ);
    assign fs.fs_o_iaddr = pc;
    assign fs.fs_o_instr = out_instr;
    assign fs.fs_o_pc    = out_pc;
    assign fs.fs_o_ce    = out_ce;

    // State and datapath registers; async reset abandons any pending request.
    always_ff @(posedge fs_clk or negedge fs_rst) begin
        if (!fs_rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            out_instr  <= '0;
            out_pc     <= '0;
            out_ce     <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
`ifdef FETCH_MISALIGN_EXC_EN
            exc        <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            out_instr  <= out_instr_nx;
            out_pc     <= out_pc_nx;
            out_ce     <= out_ce_nx;
            skid_instr <= skid_instr_nx;
            skid_pc    <= skid_pc_nx;
`ifdef FETCH_MISALIGN_EXC_EN
            exc        <= exc_nx;
`endif
        end
    end

    // Next state: redirect > flush > normal fetch/stall handling. Leaving SKID
    // is what empties the skid, so its data registers need no valid bit.
    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        out_instr_nx  = out_instr;
        out_pc_nx     = out_pc;
        out_ce_nx     = out_ce;
        skid_instr_nx = skid_instr;
        skid_pc_nx    = skid_pc;
`ifdef FETCH_MISALIGN_EXC_EN
        exc_nx        = exc;
`endif
        if (fs.fs_i_change_pc) begin
            pc_nx     = target;
            out_ce_nx = 1'b0;
            state_nx  = BUBBLE;
`ifdef FETCH_MISALIGN_EXC_EN
            exc_nx    = 1'b0;
            if (misaligned) begin
                out_ce_nx    = 1'b1;
                out_instr_nx = NOP;
                out_pc_nx    = target;
                exc_nx       = 1'b1;
                state_nx     = IDLE;
            end
`endif
        end else if (fs.fs_i_flush) begin
            // PC is not advanced, so the killed address is fetched again.
            out_ce_nx = 1'b0;
            state_nx  = BUBBLE;
`ifdef FETCH_MISALIGN_EXC_EN
            exc_nx    = 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef FETCH_MISALIGN_EXC_EN
                    if (!exc) state_nx = REQ;
`else
                    state_nx = REQ;
`endif
                end
                REQ: begin
                    if (fs.fs_i_ack) begin
                        pc_nx = pc + PC_WIDTH'(4);
                        if (fs.fs_i_stall) begin
                            skid_instr_nx = fs.fs_i_instr;
                            skid_pc_nx    = pc;
                            state_nx      = SKID;
                        end else begin
                            out_instr_nx = fs.fs_i_instr;
                            out_pc_nx    = pc;
                            out_ce_nx    = 1'b1;
                        end
                    end else if (!fs.fs_i_stall) begin
                        out_ce_nx = 1'b0;
                    end
                end
                SKID: begin
                    if (!fs.fs_i_stall) begin
                        out_instr_nx = skid_instr;
                        out_pc_nx    = skid_pc;
                        out_ce_nx    = 1'b1;
                        state_nx     = REQ;
                    end
                end
                BUBBLE: begin
                    if (!fs.fs_i_stall) out_ce_nx = 1'b0;
                    state_nx = REQ;
                end
                default: state_nx = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized stall/redirect/latency
// traffic. Expected instruction stream is the program-order PC sequence,
// restarted at each redirect target; a negedge monitor compares every
// instruction the decoder actually takes.
module tb_fetch_stage;
    localparam int          PW     = 32;
    localparam int          IW     = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    fetch_stage_if #(.PC_WIDTH(PW), .IWIDTH(IW)) bus();

    fetch_stage #(.PC_WIDTH(PW), .IWIDTH(IW), .RESET_PC(RST_PC)) dut (
        .fs_clk (clk),
        .fs_rst (rst_n),
        .fs     (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp      = 0;
    int          n_err      = 0;
    int          n_consumed = 0;
    int          mem_lat    = 0;   // <0: random 0..2 per request
    int          wait_cnt   = 0;
    bit          mon_en     = 1'b1;
    exp_t        exp_q[$];
    logic [31:0] model_next;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return 32'h0010_0093 + (a >> 2);
    endfunction

    function automatic int next_lat();
        if (mem_lat < 0) return $urandom_range(0, 2);
        return mem_lat;
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: program order is sequential PCs from the last restart point.
    task automatic model_extend();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: model_next, instr: mem_word(model_next)});
            model_next = model_next + 32'd4;
        end
    endtask

    task automatic model_restart(logic [31:0] a);
        exp_q.delete();
        model_next = a;
        model_extend();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_extend();
    endtask

    // Memory: responds with a per-request latency, never while syn is low.
    initial begin
        bus.fs_i_ack   = 1'b0;
        bus.fs_i_instr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || !bus.fs_o_syn) begin
                bus.fs_i_ack = 1'b0;
                wait_cnt     = next_lat();
            end else if (wait_cnt == 0) begin
                bus.fs_i_ack   = 1'b1;
                bus.fs_i_instr = mem_word(bus.fs_o_iaddr);
                wait_cnt       = next_lat();
            end else begin
                bus.fs_i_ack = 1'b0;
                wait_cnt--;
            end
        end
    end

    // Monitor: decoder takes an instruction when ce=1 and nothing blocks/kills it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && mon_en && bus.fs_o_ce && !bus.fs_i_stall &&
                !bus.fs_i_change_pc && !bus.fs_i_flush) begin
                n_consumed++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_empty: got pc %0h expected no output", bus.fs_o_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", bus.fs_o_pc, e.pc);
                    check("sb_instr", bus.fs_o_instr, e.instr);
                end
            end
        end
    end

    initial begin
        logic [31:0] t;
        bit          found;
        bus.fs_i_stall     = 1'b0;
        bus.fs_i_flush     = 1'b0;
        bus.fs_i_change_pc = 1'b0;
        bus.fs_i_pc_target = '0;
        model_restart(RST_PC);

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        check("rst_syn", bus.fs_o_syn, 0);
        check("rst_ce", bus.fs_o_ce, 0);
        check("rst_iaddr", bus.fs_o_iaddr, RST_PC);
        check("rst_instr", bus.fs_o_instr, 0);
        check("rst_pc", bus.fs_o_pc, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Back-to-back fetch, then a 3-cycle stall that fills the skid
        tick();
        check("req_syn", bus.fs_o_syn, 1);
        check("req_iaddr", bus.fs_o_iaddr, 0);
        check("req_ce", bus.fs_o_ce, 0);
        tick();
        check("first_ce", bus.fs_o_ce, 1);
        check("first_pc", bus.fs_o_pc, 0);
        check("first_instr", bus.fs_o_instr, mem_word(0));
        tick();
        check("second_pc", bus.fs_o_pc, 4);
        bus.fs_i_stall = 1'b1;
        tick();
        check("skid_syn", bus.fs_o_syn, 0);
        check("stall_hold_pc", bus.fs_o_pc, 4);
        check("stall_hold_ce", bus.fs_o_ce, 1);
        tick();
        check("stall_hold_pc2", bus.fs_o_pc, 4);
        tick();
        check("stall_hold_pc3", bus.fs_o_pc, 4);
        bus.fs_i_stall = 1'b0;
        tick();
        check("skid_out_pc", bus.fs_o_pc, 8);
        check("skid_out_ce", bus.fs_o_ce, 1);
        tick();
        check("after_skid_pc", bus.fs_o_pc, 12);

        // Redirect while stalled in SKID
        bus.fs_i_stall = 1'b1;
        tick();
        check("skid2_syn", bus.fs_o_syn, 0);
        bus.fs_i_change_pc = 1'b1;
        bus.fs_i_pc_target = 32'h40;
        model_restart(32'h40);
        tick();
        bus.fs_i_change_pc = 1'b0;
        bus.fs_i_stall     = 1'b0;
        check("redir_ce", bus.fs_o_ce, 0);
        check("redir_bubble_syn", bus.fs_o_syn, 0);
        check("redir_iaddr", bus.fs_o_iaddr, 32'h40);
        tick();
        check("redir_req_syn", bus.fs_o_syn, 1);
        tick();
        check("redir_out_pc", bus.fs_o_pc, 32'h40);

        // Async reset pulse off the clock edge
        #2 rst_n = 1'b0;
        mem_lat = 3;
        #1;
        check("arst_syn", bus.fs_o_syn, 0);
        check("arst_ce", bus.fs_o_ce, 0);
        check("arst_iaddr", bus.fs_o_iaddr, RST_PC);
        model_restart(RST_PC);
        #4 rst_n = 1'b1;

        // Flush while the request at 0x10 waits on slow memory
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.fs_o_syn && bus.fs_o_iaddr == 32'h10 && !bus.fs_o_ce) begin
                found = 1'b1;
                break;
            end
        end
        check("flush_setup_reached", found, 1);
        bus.fs_i_flush = found;
        tick();
        bus.fs_i_flush = 1'b0;
        check("flush_ce", bus.fs_o_ce, 0);
        check("flush_bubble_syn", bus.fs_o_syn, 0);
        check("flush_iaddr", bus.fs_o_iaddr, 32'h10);
        tick();
        check("flush_refetch_syn", bus.fs_o_syn, 1);
        check("flush_refetch_iaddr", bus.fs_o_iaddr, 32'h10);
        repeat (12) tick();

        // Redirect near the top of the address space (wraps to 0)
        mem_lat = 0;
        bus.fs_i_change_pc = 1'b1;
`ifdef FETCH_MISALIGN_EXC_EN
        bus.fs_i_pc_target = 32'hFFFF_FFF8;
`else
        bus.fs_i_pc_target = 32'hFFFF_FFFA;
`endif
        model_restart(32'hFFFF_FFF8);
        tick();
        bus.fs_i_change_pc = 1'b0;
        check("wrap_iaddr", bus.fs_o_iaddr, 32'hFFFF_FFF8);
        repeat (8) tick();

`ifdef FETCH_MISALIGN_EXC_EN
        // Misaligned redirect parks the stage with an exception NOP
        mon_en = 1'b0;
        bus.fs_i_change_pc = 1'b1;
        bus.fs_i_pc_target = 32'h42;
        tick();
        bus.fs_i_change_pc = 1'b0;
        check("exc_flag", bus.fs_o_exception, 1);
        check("exc_instr", bus.fs_o_instr, 32'h0000_0013);
        check("exc_pc", bus.fs_o_pc, 32'h42);
        check("exc_ce", bus.fs_o_ce, 1);
        check("exc_syn", bus.fs_o_syn, 0);
        tick();
        tick();
        check("exc_parked_syn", bus.fs_o_syn, 0);
        check("exc_parked_flag", bus.fs_o_exception, 1);
        bus.fs_i_change_pc = 1'b1;
        bus.fs_i_pc_target = 32'h80;
        model_restart(32'h80);
        tick();
        bus.fs_i_change_pc = 1'b0;
        check("exc_clear", bus.fs_o_exception, 0);
        check("exc_clear_ce", bus.fs_o_ce, 0);
        mon_en = 1'b1;
`endif

        // Random stalls, redirects and memory latency
        mem_lat = -1;
        for (int c = 0; c < 1500; c++) begin
            tick();
            bus.fs_i_stall     = ($urandom_range(0, 3) == 0);
            bus.fs_i_change_pc = 1'b0;
            if ($urandom_range(0, 24) == 0) begin
                t = $urandom_range(0, 4095) << 2;
                if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0;
`ifndef FETCH_MISALIGN_EXC_EN
                t[1:0] = 2'($urandom_range(0, 3));
`endif
                bus.fs_i_change_pc = 1'b1;
                bus.fs_i_pc_target = t;
                model_restart(t & ~32'h3);
            end
        end
        bus.fs_i_stall     = 1'b0;
        bus.fs_i_change_pc = 1'b0;
        repeat (10) tick();
        check("progress", n_consumed > 200, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
